// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler driving one 8N1 UART transmit line.
// A byte is accepted only while idle; the frame (start, 8 data LSB first, stop)
// is then sequenced at CLKS_PER_BIT clocks per bit. tx, busy and grant_id are registered.
module uart_tx_sched #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              tx,
  output logic              busy,
  output logic              grant_id
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax  = IdxW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [IdxW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              bit_end;
  logic [1:0]        hs;

  assign bit_end  = (baud_q == BaudMax);
  assign hs       = req_valid & req_ready;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

  // Arbitration: one-hot or zero grant, only while idle; ties go to the requester not last served.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle) begin
      unique case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_q ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  // Next-state: frame sequencing, bit timing and shift register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (hs != 2'b00) begin
          state_d = StStart;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          grant_d = hs[1];
          last_d  = hs[1];
          shift_d = hs[1] ? req_data1 : req_data0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == IdxMax) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + IdxW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset pointer favours requester 0 on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
